// File: rtl/fft_pkg.sv
// fft_pkg: shared sample type, default sizes and round-half-up arithmetic shift
package fft_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FFT_LEN_LOG2 = 10;
  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;
  function automatic logic signed [63:0] rnd_sra(input logic signed [63:0] v, input int l);
    return (v + (64'sd1 <<< (l - 1))) >>> l;
  endfunction
endpackage

// File: rtl/fft_neg_sat.sv
// fft_neg_sat: combinational two's-complement negate that saturates the most negative input
module fft_neg_sat #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a_i,
  output logic signed [W-1:0] y_o,
  output logic                ovf_o
);
  always_comb begin
    ovf_o = a_i == {1'b1, {(W-1){1'b0}}};
    y_o = ovf_o ? {1'b0, {(W-1){1'b1}}} : -a_i;
  end
endmodule

// File: rtl/fft_ifft_post_proc.sv
// fft_ifft_post_proc: conjugate, 1/N round-scale and frame-check stage turning an FFT into an IFFT
module fft_ifft_post_proc
  import fft_pkg::*;
#(
  parameter int   DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int   FFT_LEN_LOG2 = DEF_FFT_LEN_LOG2,
  parameter logic SCALE_EN     = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic signed [DATA_WIDTH-1:0] s_re_i,
  input  logic signed [DATA_WIDTH-1:0] s_im_i,
  input  logic                         s_last_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic signed [DATA_WIDTH-1:0] m_re_o,
  output logic signed [DATA_WIDTH-1:0] m_im_o,
  output logic                         m_last_o,
  output logic                         frame_err_o,
  output logic [15:0]                  sat_cnt_o
);
  localparam int W = DATA_WIDTH;
  localparam logic [FFT_LEN_LOG2-1:0] CNT_MAX = '1;
  typedef struct packed {
    logic                v;
    logic                last;
    logic                err;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } stg_t;
  function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] v);
    return SCALE_EN ? W'(rnd_sra(64'(v), FFT_LEN_LOG2)) : v;
  endfunction
  logic adv, acc, at_max, ovf;
  logic signed [W-1:0] im_n;
  logic [FFT_LEN_LOG2-1:0] cnt_q, cnt_d;
  logic [15:0] sat_q, sat_d;
  stg_t s1_q, s1_d, s2_q, s2_d;
  fft_neg_sat #(.W(W)) u_neg (.a_i(s_im_i), .y_o(im_n), .ovf_o(ovf));
  always_comb begin
    adv = !s2_q.v || m_ready_i;
    acc = s_valid_i && adv;
    at_max = cnt_q == CNT_MAX;
    cnt_d = acc ? ((s_last_i || at_max) ? '0 : cnt_q + 1'b1) : cnt_q;
    sat_d = (acc && ovf && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
    s1_d = adv ? stg_t'{v: s_valid_i, last: s_valid_i && (s_last_i || at_max),
                        err: s_valid_i && (s_last_i ^ at_max), re: s_re_i, im: im_n} : s1_q;
    s2_d = adv ? stg_t'{v: s1_q.v, last: s1_q.last, err: s1_q.err,
                        re: scale(s1_q.re), im: scale(s1_q.im)} : s2_q;
    s_ready_o = adv;
    m_valid_o = s2_q.v;
    m_re_o = s2_q.re;
    m_im_o = s2_q.im;
    m_last_o = s2_q.last;
    frame_err_o = s2_q.err;
    sat_cnt_o = sat_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sat_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
endmodule
